alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter SIMPLE_LAT, default 2, cycles from issue to a valid alu_answer for non-mul/div opcodes.
REQ-002 Parameter MUL_LAT, default 4, cycles from issue to a valid alu_answer for opcodes 5'b00010..5'b00101.
REQ-003 Parameter DIV_LAT, default 34, cycles from issue to a valid alu_answer for opcodes 5'b00110..5'b01001.
REQ-004 All latency parameters SHALL be in the range 1..63.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-008 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-009 req0_operator_1, req0_operator_2 / req1_*  input  32  operands of requester N.
REQ-010 req0_opcode / req1_opcode  input  5  ALU opcode of requester N.
REQ-011 alu_operator_1, alu_operator_2  output  32  operands driven to the shared ALU.
REQ-012 alu_opcode  output  5  opcode driven to the shared ALU.
REQ-013 alu_answer  input  32  ALU result.
REQ-014 resp_valid  output  1  result available.
REQ-015 resp_ready  input  1  consumer accepts the result.
REQ-016 resp_id  output  1  index of the requester that owns the result.
REQ-017 resp_answer  output  32  result value.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 In IDLE with at least one valid, the FSM SHALL grant exactly one requester and assert that requester's readyN combinationally.
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by pointer rr.
REQ-021 readyN SHALL be 0 in EXEC and RESP, and 0 for the requester that is not granted.
REQ-022 On the grant edge, the block SHALL:
  - register the granted operands and opcode onto the alu_* outputs;
  - set resp_id to the granted index;
  - load counter = class latency - 1;
  - enter EXEC.
REQ-023 Latency class SHALL be decoded from the granted opcode: mul range uses MUL_LAT, div range uses DIV_LAT, all other codes use SIMPLE_LAT.
REQ-024 In EXEC, alu_* outputs SHALL be held stable and the counter SHALL decrement by 1 each cycle.
REQ-025 In EXEC with counter == 0, the block SHALL capture alu_answer into resp_answer and enter RESP.
REQ-026 In RESP, resp_valid SHALL be 1, and resp_answer and resp_id SHALL be held until resp_valid && resp_ready.
REQ-027 On the RESP handshake edge, the FSM SHALL enter IDLE, clear resp_valid, and set rr to the index of the requester not just served.
REQ-028 A new grant SHALL occur no earlier than the cycle after the RESP handshake.
  - Initiation interval = latency + 2 cycles minimum.
  - resp_ready held high in RESP gives a handshake in the first RESP cycle.
REQ-029 alu_* outputs SHALL retain their last issued values in RESP and IDLE until the next grant.
REQ-030 A requester's valid dropping while not granted SHALL have no effect; the block SHALL not latch un-granted requests.

Reset
REQ-031 While rst = 1, asynchronously:
  - state = IDLE, rr = 0, counter = 0;
  - resp_valid = 0, resp_id = 0, resp_answer = 0;
  - alu_operator_1 = alu_operator_2 = 0, alu_opcode = 0;
  - busy = 0, both readies = 0.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation, and no response SHALL be produced for it afterwards.
REQ-033 The first grant after reset SHALL be possible on the first posedge with rst low.

Verification
REQ-034 Simple op: req0 valid, op 5'b00000 (add), 5 + 7, resp_ready = 1 -> req0_ready for 1 cycle; resp_valid 3 cycles after grant edge; resp_answer = 12, resp_id = 0.
REQ-035 Multiply: req1 valid, op 5'b00010, 6 x 7 -> resp_valid exactly MUL_LAT + 1 cycles after grant edge; resp_id = 1; answer = 42.
REQ-036 Both valid continuously after reset with simple ops, resp_ready = 1 -> grants alternate 0,1,0,1; each grant 4 cycles apart.
REQ-037 Response backpressure: resp_ready = 0 for 10 cycles in RESP -> resp_valid, resp_answer and resp_id stable; no readyN asserted; busy = 1; handshake on the first cycle ready rises.
REQ-038 Divide 100 / 7 (op 5'b00110), rst pulsed in the 10th EXEC cycle -> all outputs at reset values immediately; no resp_valid thereafter; next request served normally.
REQ-039 Opcode 5'b11111 -> treated as SIMPLE_LAT class; resp_valid after 3 cycles.

Source files
------------

// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared multi-cycle ALU.
// Round-robin grant, fixed per-class latency countdown, held response.
module alu_scheduler #(
    parameter int unsigned SIMPLE_LAT = 2,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned DIV_LAT    = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_operator_1,
    input  logic [31:0] req0_operator_2,
    input  logic [4:0]  req0_opcode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_operator_1,
    input  logic [31:0] req1_operator_2,
    input  logic [4:0]  req1_opcode,
    output logic [31:0] alu_operator_1,
    output logic [31:0] alu_operator_2,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_answer,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_answer,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [5:0] SIMPLE_CNT = 6'(SIMPLE_LAT - 1);
    localparam logic [5:0] MUL_CNT    = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT    = 6'(DIV_LAT - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  opc_q, opc_d;
    logic        id_q, id_d;
    logic [31:0] ans_q, ans_d;

    logic        gnt1;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_op;
    logic [5:0]  sel_cnt;
    logic        is_mul;
    logic        is_div;

    // requester 1 wins when alone or when the pointer favours it
    always_comb begin
        gnt1   = req1_valid && (!req0_valid || rr_q);
        sel_a  = gnt1 ? req1_operator_1 : req0_operator_1;
        sel_b  = gnt1 ? req1_operator_2 : req0_operator_2;
        sel_op = gnt1 ? req1_opcode : req0_opcode;
        is_mul = (sel_op >= 5'd2) && (sel_op <= 5'd5);
        is_div = (sel_op >= 5'd6) && (sel_op <= 5'd9);
        sel_cnt = SIMPLE_CNT;
        unique case (1'b1)
            is_mul:  sel_cnt = MUL_CNT;
            is_div:  sel_cnt = DIV_CNT;
            default: sel_cnt = SIMPLE_CNT;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        opc_d      = opc_q;
        id_d       = id_q;
        ans_d      = ans_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    req0_ready = !gnt1;
                    req1_ready = gnt1;
                    a_d        = sel_a;
                    b_d        = sel_b;
                    opc_d      = sel_op;
                    id_d       = gnt1;
                    cnt_d      = sel_cnt;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 6'd0) begin
                    ans_d   = alu_answer;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rr_d    = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            opc_q   <= 5'd0;
            id_q    <= 1'b0;
            ans_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            id_q    <= id_d;
            ans_q   <= ans_d;
        end
    end

    assign alu_operator_1 = a_q;
    assign alu_operator_2 = b_q;
    assign alu_opcode     = opc_q;
    assign resp_valid     = (state_q == RESP);
    assign resp_id        = id_q;
    assign resp_answer    = ans_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: timestamp-based transaction model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_alu_scheduler;

    localparam int SL = 2;
    localparam int ML = 4;
    localparam int DL = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_operator_1 = '0, req0_operator_2 = '0;
    logic [31:0] req1_operator_1 = '0, req1_operator_2 = '0;
    logic [4:0]  req0_opcode = '0, req1_opcode = '0;
    logic [31:0] alu_operator_1, alu_operator_2;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_answer;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [31:0] resp_answer;
    logic        busy;

    int nvec = 0;
    int nfail = 0;

    alu_scheduler #(
        .SIMPLE_LAT(SL), .MUL_LAT(ML), .DIV_LAT(DL)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_operator_1(req0_operator_1), .req0_operator_2(req0_operator_2),
        .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_operator_1(req1_operator_1), .req1_operator_2(req1_operator_2),
        .req1_opcode(req1_opcode),
        .alu_operator_1(alu_operator_1), .alu_operator_2(alu_operator_2),
        .alu_opcode(alu_opcode), .alu_answer(alu_answer),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_answer(resp_answer), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [4:0] op,
                                          input logic [31:0] a, b);
        if (op == 5'd0) return a + b;
        if (op == 5'd1) return a - b;
        if (op >= 5'd2 && op <= 5'd5) return a * b;
        if (op >= 5'd6 && op <= 5'd9) return (b == 0) ? '1 : a / b;
        return a ^ b;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op >= 5'd2 && op <= 5'd5) return ML;
        if (op >= 5'd6 && op <= 5'd9) return DL;
        return SL;
    endfunction

    assign alu_answer = alu_fn(alu_opcode, alu_operator_1, alu_operator_2);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a grant starts a job whose result appears at a
    // known cycle number and stays until the consumer takes it.
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_owner = 0;
    int          m_rv_cyc = 0;
    logic        m_rr = 0;
    logic [31:0] m_a = 0, m_b = 0, m_pend = 0, m_ans = 0;
    logic [4:0]  m_op = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_rr = 0; m_a = 0; m_b = 0;
            m_op = 0; m_ans = 0; m_owner = 0;
        end else begin
            if (m_busy) begin
                if (cyc >= m_rv_cyc && resp_ready) begin
                    m_busy = 0;
                    m_rr = ~m_owner;
                end else if (cyc + 1 == m_rv_cyc) begin
                    m_ans = m_pend;
                end
            end else if (req0_valid || req1_valid) begin
                m_owner = req1_valid && (!req0_valid || m_rr);
                m_a  = m_owner ? req1_operator_1 : req0_operator_1;
                m_b  = m_owner ? req1_operator_2 : req0_operator_2;
                m_op = m_owner ? req1_opcode : req0_opcode;
                m_pend = alu_fn(m_op, m_a, m_b);
                m_rv_cyc = cyc + 1 + lat_of(m_op);
                m_busy = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic e0, e1, erv;
        erv = m_busy && (cyc >= m_rv_cyc);
        e0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_rr);
        e1 = !rst && !m_busy && req1_valid && (!req0_valid || m_rr);
        chk("m_busy", busy, m_busy);
        chk("m_ready0", req0_ready, e0);
        chk("m_ready1", req1_ready, e1);
        chk("m_resp_valid", resp_valid, erv);
        chk("m_resp_id", resp_id, m_owner);
        chk("m_resp_answer", resp_answer, m_ans);
        chk("m_alu_a", alu_operator_1, m_a);
        chk("m_alu_b", alu_operator_2, m_b);
        chk("m_alu_op", alu_opcode, m_op);
    end

    task automatic issue(input bit who, input logic [4:0] op,
                         input logic [31:0] a, b, output int n);
        bit got;
        got = 0;
        if (who) begin
            req1_valid = 1; req1_opcode = op;
            req1_operator_1 = a; req1_operator_2 = b;
        end else begin
            req0_valid = 1; req0_opcode = op;
            req0_operator_1 = a; req0_operator_2 = b;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (who ? req1_ready : req0_ready) got = 1;
        end
        chk("grant_seen", got, 1);
        @(posedge clk); #2;
        if (who) req1_valid = 0; else req0_valid = 0;
        n = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1;
        end
        chk("resp_seen", got, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        int gc[4];
        bit gi[4];
        bit seen;
        #1 rst = 1;
        req0_valid = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_answer", resp_answer, 0);
        req0_valid = 0;
        @(posedge clk); #2;
        rst = 0;
        resp_ready = 1;

        issue(0, 5'd0, 32'd5, 32'd7, n);
        chk("add_lat", n, SL + 1);
        chk("add_ans", resp_answer, 12);
        chk("add_id", resp_id, 0);
        @(posedge clk); #2;

        issue(1, 5'd2, 32'd6, 32'd7, n);
        chk("mul_lat", n, ML + 1);
        chk("mul_ans", resp_answer, 42);
        chk("mul_id", resp_id, 1);
        @(posedge clk); #2;

        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        req0_valid = 1; req0_opcode = 5'd0;
        req0_operator_1 = 1; req0_operator_2 = 2;
        req1_valid = 1; req1_opcode = 5'd1;
        req1_operator_1 = 10; req1_operator_2 = 3;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gc[k] = i; gi[k] = req1_ready; k++;
            end
        end
        @(posedge clk); #2;
        req0_valid = 0; req1_valid = 0;
        chk("alt_count", k, 4);
        for (int j = 0; j < 4; j++) chk("alt_id", gi[j], j % 2);
        for (int j = 1; j < 4; j++) chk("alt_gap", gc[j] - gc[j-1], 4);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        chk("alt_idle", seen, 1);
        @(posedge clk); #2;

        resp_ready = 0;
        issue(0, 5'd0, 32'd20, 32'd22, n);
        chk("bp_lat", n, SL + 1);
        #1;
        req1_valid = 1; req1_opcode = 5'd0;
        req1_operator_1 = 1; req1_operator_2 = 1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_ans", resp_answer, 42);
            chk("bp_id", resp_id, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #2;
        resp_ready = 1;
        req1_valid = 0;
        @(negedge clk);
        chk("bp_hs_valid", resp_valid, 1);
        @(negedge clk);
        chk("bp_after_valid", resp_valid, 0);
        chk("bp_after_busy", busy, 0);
        @(posedge clk); #2;

        req0_valid = 1; req0_opcode = 5'd6;
        req0_operator_1 = 100; req0_operator_2 = 7;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req0_ready) seen = 1;
        end
        chk("div_grant", seen, 1);
        @(posedge clk); #2;
        req0_valid = 0;
        repeat (9) @(posedge clk);
        #2;
        chk("div_busy", busy, 1);
        rst = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", resp_valid, 0);
        chk("abort_ans", resp_answer, 0);
        chk("abort_alu_a", alu_operator_1, 0);
        chk("abort_alu_op", alu_opcode, 0);
        chk("abort_id", resp_id, 0);
        @(posedge clk); #2;
        rst = 0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("abort_noresp", seen, 0);
        @(posedge clk); #2;

        issue(0, 5'd6, 32'd100, 32'd7, n);
        chk("div_lat", n, DL + 1);
        chk("div_ans", resp_answer, 14);
        @(posedge clk); #2;

        issue(1, 5'd31, 32'hF0, 32'h0F, n);
        chk("op31_lat", n, SL + 1);
        chk("op31_ans", resp_answer, 32'hFF);
        chk("op31_id", resp_id, 1);
        @(posedge clk); #2;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
